d16_io_responder: RTL and testbench
===================================

Name: d16_io_responder

Overview:
- Memory-mapped I/O responder on the d16 core's data bus. The core is the initiator; this block is the responder end of the same bus.
- Decodes a small I/O window and returns read data with a req/ack handshake after a programmable number of wait states.
- Owns the LED register that drives the board LED[4:0] pins, plus a 16-bit timer with compare flag and a synchronised 5-bit switch input.
- Sits between the core's data port and the board pins at the top level.

Parameters:
- ADDR_W, 8, width of the I/O address bus (word addresses).
- WAIT_STATES, 1, cycles inserted between request capture and ack (0..7).
- TIMER_PRESCALE, 4, clock cycles per timer tick (>=1).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  bus request from core; held high until ack.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  word address.
- wdata  in  16  write data.
- rdata  out  16  read data; valid only in the ack cycle.
- ack  out  1  single-cycle completion strobe.
- sw  in  5  asynchronous board switches.
- LED  out  5  LED register output.
- irq  out  1  timer compare flag, level.

Behaviour:
- Reset (async, immediate): ack=0, rdata=0, LED=0, irq=0, timer=0, compare=16'hFFFF, timer enable=0, prescaler=0, sw sync regs=0, FSM=IDLE.
- Register map (word address):
  - 0x00 LED: rw, bits[4:0]; upper bits read 0.
  - 0x01 SW: ro, 2-flop-synchronised sw; writes are ignored.
  - 0x02 TIMER: rw; a write loads the count.
  - 0x03 COMPARE: rw.
  - 0x04 CTRL: bit0 enable; bit1 irq flag. Writing 1 to bit1 clears the flag (W1C).
  - Other addresses: read 0, writes ignored, still acked. No bus hang.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on req=1, capture we/addr/wdata. Go to WAIT if WAIT_STATES>0, else ACK.
  - WAIT: count WAIT_STATES cycles, then go to ACK.
  - ACK: ack=1 for exactly one cycle; writes commit on this edge; rdata is driven from the registers as of this cycle. Next state is IDLE.
  - rdata returns to 0 when ack=0.
- Latency: ack is asserted WAIT_STATES+1 cycles after the cycle req is first sampled high.
  - WAIT_STATES=0 gives ack on the cycle after capture.
  - The core drops req in the cycle after ack.
  - If req is still high in the IDLE cycle after ack, it is treated as a new request (back-to-back accesses are legal).
- req falling before ack is a protocol violation. The transaction still completes and acks using the captured values.
- Timer:
  - When enabled, the prescaler counts 0..TIMER_PRESCALE-1. On wrap, timer increments and wraps 16'hFFFF to 0.
  - When timer == compare at a tick increment, the irq flag is set.
- Simultaneous events:
  - A CPU write to TIMER in the same cycle as a tick: the write wins; the prescaler is unaffected.
  - A W1C of the flag in the same cycle as a compare set: the set wins (flag stays 1).
  - Disable via CTRL freezes both timer and prescaler; re-enable resumes from the held values.
- Reset mid-transaction aborts it. No ack is issued and no write commits.
- SW read value lags the pin by 2 clocks (synchroniser).

Test Plan:
- Reset then write LED: with rst high for 2 cycles, then write 0x00=16'h0015 → LED=5'b10101 on the ack edge. A read of 0x00 returns 16'h0015 with ack exactly WAIT_STATES+1 cycles after req.
- Wait-state sweep: WAIT_STATES=0,1,3, back-to-back reads of 0x03 with req held → one ack per access, spaced 1/2/4 cycles apart, rdata=16'hFFFF each time.
- Timer compare: set COMPARE=3 and CTRL=1 with TIMER_PRESCALE=4 → irq rises 16 clocks after enable. Writing CTRL=16'h0003 clears irq, and the timer keeps counting.
- Switch sync: change sw from 0 to 5'b01101 → a read of 0x01 returns 0 within the first 2 clocks, then 16'h000D.
- Unmapped/edge cases: a write to 0x7F is acked and the registers are unchanged; a read of 0x7F returns 0.
- Reset mid-operation: assert rst in WAIT during a write to LED → ack never pulses, LED=0, FSM returns to IDLE, and the next access completes normally.

Source files
------------

// File: rtl/d16_io_responder.sv
// d16_io_responder: memory-mapped I/O responder on the d16 data bus with a wait-state req/ack handshake.
// Owns the LED register, a prescaled 16-bit timer with compare flag and a 2-flop switch synchroniser.
module d16_io_responder #(
  parameter int ADDR_W         = 8,
  parameter int WAIT_STATES    = 1,
  parameter int TIMER_PRESCALE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              ack,
  input  logic [4:0]        sw,
  output logic [4:0]        LED,
  output logic              irq
);

  localparam int              PS_W    = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TIMER_PRESCALE - 1);
  localparam logic [2:0]      WS_LAST = 3'(WAIT_STATES - 1);

  localparam logic [ADDR_W-1:0] A_LED   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_SW    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TIMER = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_CMP   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic              ack_q, ack_d;
  logic              cap_s;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [4:0]        led_q, led_d;
  logic [15:0]       timer_q, timer_d;
  logic [15:0]       cmp_q, cmp_d;
  logic              en_q, en_d;
  logic              flag_q, flag_d;
  logic [PS_W-1:0]   pre_q, pre_d;
  logic [4:0]        sw_meta_q, sw_sync_q;
  logic              tick_s;
  logic              commit_s;
  logic [15:0]       rd_s;

  // Handshake FSM; ack_q mirrors the ACK state so the strobe comes straight from a flop.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cap_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cap_s = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = 3'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wcnt_q == WS_LAST) begin
          state_d = S_ACK;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ack_d = (state_d == S_ACK);
  end

  // Timer and register updates; CPU writes override the tick, a compare hit overrides the W1C.
  always_comb begin
    led_d    = led_q;
    timer_d  = timer_q;
    cmp_d    = cmp_q;
    en_d     = en_q;
    flag_d   = flag_q;
    pre_d    = pre_q;
    tick_s   = en_q && (pre_q == PS_LAST);
    commit_s = ack_q && we_q;
    if (en_q) begin
      pre_d = tick_s ? '0 : pre_q + PS_W'(1);
    end else begin
      pre_d = pre_q;
    end
    if (tick_s) begin
      timer_d = timer_q + 16'd1;
    end else begin
      timer_d = timer_q;
    end
    if (commit_s) begin
      case (addr_q)
        A_LED:   led_d   = wdata_q[4:0];
        A_TIMER: timer_d = wdata_q;
        A_CMP:   cmp_d   = wdata_q;
        A_CTRL: begin
          en_d = wdata_q[0];
          if (wdata_q[1]) begin
            flag_d = 1'b0;
          end else begin
            flag_d = flag_q;
          end
        end
        default: led_d = led_q;
      endcase
    end else begin
      led_d = led_q;
    end
    if (tick_s && (timer_q == cmp_q)) begin
      flag_d = 1'b1;
    end else begin
      flag_d = flag_d;
    end
  end

  always_comb begin
    rd_s = 16'd0;
    case (addr_q)
      A_LED:   rd_s = {11'd0, led_q};
      A_SW:    rd_s = {11'd0, sw_sync_q};
      A_TIMER: rd_s = timer_q;
      A_CMP:   rd_s = cmp_q;
      A_CTRL:  rd_s = {14'd0, flag_q, en_q};
      default: rd_s = 16'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wcnt_q    <= 3'd0;
      ack_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 16'd0;
      led_q     <= 5'd0;
      timer_q   <= 16'd0;
      cmp_q     <= 16'hFFFF;
      en_q      <= 1'b0;
      flag_q    <= 1'b0;
      pre_q     <= '0;
      sw_meta_q <= 5'd0;
      sw_sync_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      ack_q     <= ack_d;
      if (cap_s) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      led_q     <= led_d;
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
      en_q      <= en_d;
      flag_q    <= flag_d;
      pre_q     <= pre_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign ack   = ack_q;
  assign rdata = ack_q ? rd_s : 16'd0;
  assign LED   = led_q;
  assign irq   = flag_q;

endmodule

// File: tb/tb_d16_io_responder.sv
// Bench for d16_io_responder: directed scenarios plus randomized bus traffic against a register-map model.
module tb_d16_io_responder;

  localparam int WS = 1;
  localparam int PS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req0, req3, we;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [4:0]  sw;
  logic [15:0] rdata, rdata0, rdata3;
  logic        ack, ack0, ack3;
  logic        irq, irq0, irq3;
  logic [4:0]  led, led0, led3;

  int checks = 0;
  int errors = 0;

  // reference model of the register map
  logic [4:0]  m_led, m_sw1, m_sw2;
  logic [15:0] m_timer, m_cmp;
  logic        m_en, m_flag;
  int          m_phase;
  int          pend_cnt;
  logic        pend_w;
  logic [7:0]  pend_a;
  logic [15:0] pend_d;

  always #5 clk = ~clk;

  d16_io_responder #(.ADDR_W(8), .WAIT_STATES(WS), .TIMER_PRESCALE(PS)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .sw(sw), .LED(led), .irq(irq));

  d16_io_responder #(.ADDR_W(8), .WAIT_STATES(0), .TIMER_PRESCALE(PS)) u_ws0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .ack(ack0), .sw(sw), .LED(led0), .irq(irq0));

  d16_io_responder #(.ADDR_W(8), .WAIT_STATES(3), .TIMER_PRESCALE(PS)) u_ws3 (
    .clk(clk), .rst(rst), .req(req3), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .ack(ack3), .sw(sw), .LED(led3), .irq(irq3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_led = 5'd0; m_timer = 16'd0; m_cmp = 16'hFFFF; m_en = 1'b0; m_flag = 1'b0;
    m_phase = 0; m_sw1 = 5'd0; m_sw2 = 5'd0; pend_cnt = 0;
  endtask

  function automatic logic [15:0] model_read(input logic [7:0] a);
    case (a)
      8'h00:   return {11'd0, m_led};
      8'h01:   return {11'd0, m_sw2};
      8'h02:   return m_timer;
      8'h03:   return m_cmp;
      8'h04:   return {14'd0, m_flag, m_en};
      default: return 16'd0;
    endcase
  endfunction

  task automatic model_edge();
    logic tk, hit;
    if (rst) begin
      model_reset();
      return;
    end
    tk  = m_en && (m_phase == PS - 1);
    hit = tk && (m_timer == m_cmp);
    if (m_en) m_phase = (m_phase + 1) % PS;
    if (tk) m_timer = m_timer + 16'd1;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0 && pend_w) begin
        case (pend_a)
          8'h00: m_led = pend_d[4:0];
          8'h02: m_timer = pend_d;
          8'h03: m_cmp = pend_d;
          8'h04: begin
            m_en = pend_d[0];
            if (pend_d[1]) m_flag = 1'b0;
          end
          default: ;
        endcase
      end
    end
    if (hit) m_flag = 1'b1;
    m_sw2 = m_sw1;
    m_sw1 = sw;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic xfer(input logic w, input logic [7:0] a, input logic [15:0] d, input string tag);
    req = 1'b1; we = w; addr = a; wdata = d;
    pend_w = w; pend_a = a; pend_d = d; pend_cnt = WS + 2;
    for (int c = 1; c <= WS; c++) begin
      step();
      check({tag, "/early_ack"}, 32'(ack), 32'd0);
    end
    step();
    check({tag, "/ack"}, 32'(ack), 32'd1);
    check({tag, "/rdata"}, 32'(rdata), 32'(model_read(a)));
    req = 1'b0;
    step();
    check({tag, "/ack_low"}, 32'(ack), 32'd0);
    check({tag, "/rdata_idle"}, 32'(rdata), 32'd0);
    check({tag, "/led"}, 32'(led), 32'(m_led));
    check({tag, "/irq"}, 32'(irq), 32'(m_flag));
  endtask

  task automatic run_random(input int n);
    logic [7:0]  a;
    logic        w;
    logic [15:0] d;
    int          r;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      if (r <= 4)      a = 8'(r);
      else if (r == 5) a = 8'h7F;
      else if (r == 6) a = 8'($urandom_range(5, 255));
      else             a = 8'h04;
      if (a == 8'h02) d = m_cmp - 16'($urandom_range(0, 2));
      if (a == 8'h03) d = 16'($urandom_range(0, 40));
      if (a == 8'h04) d = {14'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)};
      if ($urandom_range(0, 3) == 0) sw = 5'($urandom);
      xfer(w, a, d, "rnd");
      for (int g = 0; g < int'($urandom_range(0, 5)); g++) begin
        step();
        check("rnd_gap_irq", 32'(irq), 32'(m_flag));
        check("rnd_gap_ack", 32'(ack), 32'd0);
      end
    end
  endtask

  initial begin
    int n0, n1, n3;
    logic e0, e1, e3;
    rst = 1'b1; req = 1'b0; req0 = 1'b0; req3 = 1'b0; we = 1'b0;
    addr = 8'h00; wdata = 16'h0000; sw = 5'd0;
    pend_w = 1'b0; pend_a = 8'h00; pend_d = 16'h0000;
    model_reset();
    step();
    step();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    step();

    // LED write then read back
    xfer(1'b1, 8'h00, 16'h0015, "led_w");
    check("led_value", 32'(led), 32'h15);
    xfer(1'b0, 8'h00, 16'h0000, "led_r");

    // back-to-back reads of COMPARE with req held on three wait-state variants
    req = 1'b1; req0 = 1'b1; req3 = 1'b1; we = 1'b0; addr = 8'h03;
    n0 = 0; n1 = 0; n3 = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      e0 = (c % 2 == 1);
      e1 = (c % 3 == 2);
      e3 = (c % 5 == 4);
      check("sweep_ws0_ack", 32'(ack0), 32'(e0));
      check("sweep_ws1_ack", 32'(ack), 32'(e1));
      check("sweep_ws3_ack", 32'(ack3), 32'(e3));
      check("sweep_ws0_rdata", 32'(rdata0), e0 ? 32'hFFFF : 32'd0);
      check("sweep_ws1_rdata", 32'(rdata), e1 ? 32'hFFFF : 32'd0);
      check("sweep_ws3_rdata", 32'(rdata3), e3 ? 32'hFFFF : 32'd0);
      n0 += int'(ack0);
      n1 += int'(ack);
      n3 += int'(ack3);
    end
    req = 1'b0; req0 = 1'b0; req3 = 1'b0;
    check("sweep_ws0_count", 32'(n0), 32'd10);
    check("sweep_ws1_count", 32'(n1), 32'd7);
    check("sweep_ws3_count", 32'(n3), 32'd4);
    for (int i = 0; i < 5; i++) step();

    // timer compare: irq 16 clocks after enable, W1C clears while timer keeps counting
    xfer(1'b1, 8'h03, 16'h0003, "cmp_w");
    xfer(1'b1, 8'h04, 16'h0001, "ctrl_en");
    for (int i = 1; i <= 16; i++) begin
      step();
      check("timer_irq_rise", 32'(irq), 32'(i == 16));
    end
    xfer(1'b1, 8'h04, 16'h0003, "ctrl_w1c");
    check("w1c_irq_clear", 32'(irq), 32'd0);
    xfer(1'b0, 8'h02, 16'h0000, "timer_r1");
    for (int i = 0; i < 8; i++) step();
    xfer(1'b0, 8'h02, 16'h0000, "timer_r2");
    xfer(1'b0, 8'h04, 16'h0000, "ctrl_r");

    // switch synchroniser seen through the zero-wait-state instance
    sw = 5'b01101; req0 = 1'b1; we = 1'b0; addr = 8'h01;
    step();
    check("sw_early_ack", 32'(ack0), 32'd1);
    check("sw_early_val", 32'(rdata0), 32'd0);
    step();
    check("sw_gap_ack", 32'(ack0), 32'd0);
    step();
    check("sw_late_ack", 32'(ack0), 32'd1);
    check("sw_late_val", 32'(rdata0), 32'h000D);
    req0 = 1'b0;
    step();
    xfer(1'b0, 8'h01, 16'h0000, "sw_r");

    // unmapped address
    xfer(1'b1, 8'h7F, 16'hBEEF, "unm_w");
    check("unm_led_kept", 32'(led), 32'h15);
    xfer(1'b0, 8'h7F, 16'h0000, "unm_r");
    xfer(1'b0, 8'h03, 16'h0000, "unm_cmp_r");

    // reset while the LED write is waiting
    req = 1'b1; we = 1'b1; addr = 8'h00; wdata = 16'h001F;
    step();
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_led", 32'(led), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    req = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_ack", 32'(ack), 32'd0);
      check("post_rst_led", 32'(led), 32'd0);
    end
    xfer(1'b1, 8'h00, 16'h000A, "post_rst_w");
    check("post_rst_led_val", 32'(led), 32'h0A);
    xfer(1'b0, 8'h04, 16'h0000, "post_rst_ctrl");

    run_random(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
